// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - board timing constants and parameter defaults for the button debouncer
package btn_pkg;

    localparam int CLK_HZ      = 12_000_000;
    localparam int DEBOUNCE_MS = 20;
    localparam int LONG_MS     = 1000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int               N_BTN_DEF           = 4;
    localparam int               SYNC_STAGES_DEF     = 2;
    localparam int               DEBOUNCE_CYCLES_DEF = ms_to_cycles(DEBOUNCE_MS);
    localparam int               LONG_CYCLES_DEF     = ms_to_cycles(LONG_MS);
    // bit 0 is btn_n, the only active-low pin on this board
    localparam logic [N_BTN_DEF-1:0] ACTIVE_LOW_MASK_DEF = 4'b0001;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchroniser, polarity fix, debounce, strobes
// Optional hold counter for btn_long under BUTTON_DEBOUNCER_LONG_PRESS_EN.
import btn_pkg::*;

module btn_debounce_ch #(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], raw_i};
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d   = s;
            cnt_d     = '0;
            press_d   = s;
            release_d = ~s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= {SYNC_STAGES{ACTIVE_LOW}};
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int             LW       = $clog2(LONG_CYCLES);
    localparam logic [LW-1:0]  HOLD_MAX = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] hold_q, hold_d;
    logic          done_q, done_d;
    logic          long_q, long_d;

    // done_q keeps the saturated counter from re-firing while the button stays held
    always_comb begin
        hold_d = hold_q;
        done_d = done_q;
        long_d = 1'b0;
        if (!level_q) begin
            hold_d = '0;
            done_d = 1'b0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end else if (!done_q) begin
            long_d = 1'b1;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
            done_q <= 1'b0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            done_q <= done_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    logic unused_long;
    assign unused_long = (LONG_CYCLES > 0);
    assign long_o      = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - N_BTN independent debounced button channels
// Long-press strobe only with BUTTON_DEBOUNCER_LONG_PRESS_EN defined.
import btn_pkg::*;

module button_debouncer #(
    parameter int               N_BTN           = N_BTN_DEF,
    parameter int               SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = ACTIVE_LOW_MASK_DEF,
    parameter int               LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW_MASK[i])
        ) u_ch (
            .clk_i    (clk),
            .rst_i    (rst),
            .raw_i    (btn_raw[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i]),
            .long_o   (btn_long[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer (D=4, LONG=10, SYNC=2)
`timescale 1ns/1ps

module tb_button_debouncer;

    localparam int LAT  = 6;   // SYNC_STAGES + DEBOUNCE_CYCLES
    localparam int LONG = 10;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level, btn_press, btn_release, btn_long;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    button_debouncer #(
        .N_BTN          (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW_MASK(4'b0001),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.lng = l;
        sb.push_back(e);
    endtask

    // advance to the next falling edge and compare strobes against the scoreboard
    task automatic tick();
        ev_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missed_event cyc=%0d expected at %0d press=%b rel=%b long=%b",
                     cyc, sb[0].cyc, sb[0].press, sb[0].rel, sb[0].lng);
            void'(sb.pop_front());
        end
        checks++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            if (btn_press !== e.press || btn_release !== e.rel || btn_long !== e.lng) begin
                errors++;
                $display("FAIL strobe_event cyc=%0d got press=%b rel=%b long=%b want press=%b rel=%b long=%b",
                         cyc, btn_press, btn_release, btn_long, e.press, e.rel, e.lng);
            end
        end else if ({btn_press, btn_release, btn_long} !== 12'h000) begin
            errors++;
            $display("FAIL unexpected_strobe cyc=%0d got press=%b rel=%b long=%b want all 0",
                     cyc, btn_press, btn_release, btn_long);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_raw = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (btn_level !== 4'b0000) begin
                errors++;
                $display("FAIL reset_level_during got %b want 0000", btn_level);
            end
        end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (btn_level !== 4'b0000) begin
            errors++;
            $display("FAIL reset_level_after got %b want 0000", btn_level);
        end
    endtask

    task automatic test_press_release();
        int c;
        c = cyc;
        btn_raw[1] = 1'b1;
        push(c + LAT, 4'b0010, 4'b0000, 4'b0000);
        repeat (LAT - 1) tick();
        checks++;
        if (btn_level !== 4'b0000) begin
            errors++;
            $display("FAIL press_early_level got %b want 0000", btn_level);
        end
        tick();
        checks++;
        if (btn_level !== 4'b0010) begin
            errors++;
            $display("FAIL press_level got %b want 0010", btn_level);
        end
        tick();
        c = cyc;
        btn_raw[1] = 1'b0;
        push(c + LAT, 4'b0000, 4'b0010, 4'b0000);
        repeat (LAT + 2) tick();
        checks++;
        if (btn_level !== 4'b0000) begin
            errors++;
            $display("FAIL release_level got %b want 0000", btn_level);
        end
    endtask

    task automatic test_glitch();
        btn_raw[2] = 1'b1;
        repeat (3) tick();
        btn_raw[2] = 1'b0;
        repeat (LAT) tick();
        checks++;
        if (btn_level[2] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_short_level got %b want 0", btn_level[2]);
        end
        for (int k = 0; k < 3; k++) begin
            btn_raw[2] = 1'b1;
            repeat (3) tick();
            btn_raw[2] = 1'b0;
            tick();
        end
        repeat (LAT) tick();
        checks++;
        if (btn_level[2] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_bounce_level got %b want 0", btn_level[2]);
        end
    endtask

    task automatic test_simultaneous();
        int c;
        c = cyc;
        btn_raw = 4'b1000;
        push(c + LAT, 4'b1001, 4'b0000, 4'b0000);
        repeat (LAT + 1) tick();
        checks++;
        if (btn_level !== 4'b1001) begin
            errors++;
            $display("FAIL simul_level got %b want 1001", btn_level);
        end
        c = cyc;
        btn_raw = 4'b0001;
        push(c + LAT, 4'b0000, 4'b1001, 4'b0000);
        repeat (LAT + 2) tick();
        checks++;
        if (btn_level !== 4'b0000) begin
            errors++;
            $display("FAIL simul_release_level got %b want 0000", btn_level);
        end
    endtask

    task automatic test_reset_mid_count();
        int r;
        btn_raw[1] = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (btn_level !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_level got %b want 0000", btn_level);
        end
        rst = 1'b0;
        r = cyc;
        push(r + LAT, 4'b0010, 4'b0000, 4'b0000);
        if (LONG_EN) push(r + LAT + LONG, 4'b0000, 4'b0000, 4'b0010);
        repeat (LAT - 1) tick();
        checks++;
        if (btn_level !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_early_level got %b want 0000", btn_level);
        end
        tick();
        checks++;
        if (btn_level !== 4'b0010) begin
            errors++;
            $display("FAIL rst_mid_press_level got %b want 0010", btn_level);
        end
    endtask

    task automatic test_long_press();
        int c;
        repeat (3 * LONG) tick();
        checks++;
        if (btn_level !== 4'b0010) begin
            errors++;
            $display("FAIL long_hold_level got %b want 0010", btn_level);
        end
        c = cyc;
        btn_raw[1] = 1'b0;
        push(c + LAT, 4'b0000, 4'b0010, 4'b0000);
        repeat (LAT + 2) tick();
    endtask

    initial begin
        rst = 1'b1;
        btn_raw = 4'b0001;
        test_reset();
        test_press_release();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
        test_long_press();
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
